// File: rtl/controlador_display_pkg.sv
// Shared types and constants for the 3-digit multiplexed display controller.
package pkg_display;

    typedef enum logic [1:0] {
        REPOSO,
        DESPLAZA,
        ACTUALIZA
    } estado_t;

    localparam int NUM_DIGITOS = 3;
    localparam int ANCHO_BIN = 8;
    localparam logic [3:0] DIGITO_INVALIDO = 4'hF;

    // Add-3 correction applied to every BCD nibble of 5 or more before each shift.
    function automatic logic [11:0] ajustar_bcd(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/controlador_display_bin_a_bcd.sv
// Sequential binary-to-BCD converter (double dabble), one iteration per clock.
//
// state     | meaning
// ----------|---------------------------------------------------------------
// REPOSO    | idle; accepts inicio and latches the binary operand
// DESPLAZA  | one add-3 + shift iteration per edge, eight in total
// ACTUALIZA | copies the finished scratch into bcd and pulses listo
module bin_a_bcd
    import pkg_display::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inicio,
    input  logic [ANCHO_BIN-1:0] bin,
    output logic                 ocupado,
    output logic                 listo,
    output logic [11:0]          bcd
);

    localparam logic [3:0] ULTIMA_ITER = 4'(ANCHO_BIN - 1);

    estado_t              estado;
    logic [3:0]           cuenta;
    logic [ANCHO_BIN-1:0] bin_sr;
    logic [11:0]          scratch;
    logic [11:0]          ajustado;

    assign ajustado = ajustar_bcd(scratch);
    assign ocupado  = (estado != REPOSO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado  <= REPOSO;
            cuenta  <= '0;
            bin_sr  <= '0;
            scratch <= '0;
            bcd     <= '0;
            listo   <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (inicio) begin
                        bin_sr  <= bin;
                        scratch <= '0;
                        cuenta  <= '0;
                        estado  <= DESPLAZA;
                    end
                end
                DESPLAZA: begin
                    {scratch, bin_sr} <= {ajustado, bin_sr} << 1;
                    cuenta            <= cuenta + 4'd1;
                    if (cuenta == ULTIMA_ITER) begin
                        estado <= ACTUALIZA;
                    end
                end
                ACTUALIZA: begin
                    bcd    <= scratch;
                    listo  <= 1'b1;
                    estado <= REPOSO;
                end
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule

// File: rtl/controlador_display.sv
// Converts a loaded 8-bit value to BCD and time-multiplexes the three digits
// onto a shared digit bus with one-hot anode selects.
module controlador_display
    import pkg_display::*;
#(
    parameter int DIV_ESCANEO       = 50000,
    parameter bit ANODO_ACTIVO_BAJO = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] valor,
    input  logic       cargar,
    output logic       ocupado,
    output logic       listo,
    output logic [3:0] digito,
    output logic [2:0] anodos
);

    localparam int ANCHO_PRE = (DIV_ESCANEO > 2) ? $clog2(DIV_ESCANEO) : 1;
    localparam logic [ANCHO_PRE-1:0] PRE_MAX = ANCHO_PRE'(DIV_ESCANEO - 1);

    logic [11:0]          bcd_reg;
    logic                 valido;
    logic                 mostrar;
    logic [ANCHO_PRE-1:0] prescaler;
    logic [1:0]           indice;
    logic                 tick;
    logic [2:0]           una_activa;

    bin_a_bcd u_bin_a_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .inicio  (cargar),
        .bin     (valor),
        .ocupado (ocupado),
        .listo   (listo),
        .bcd     (bcd_reg)
    );

    // bcd_reg and listo land on the same edge, so listo covers the first cycle
    // before valido has registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valido <= 1'b0;
        end else if (listo) begin
            valido <= 1'b1;
        end
    end

    assign mostrar = valido | listo;
    assign tick    = (prescaler == PRE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            indice    <= '0;
        end else if (tick) begin
            prescaler <= '0;
            indice    <= (indice == 2'd2) ? 2'd0 : indice + 2'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_comb begin
        digito = DIGITO_INVALIDO;
        if (mostrar) begin
            case (indice)
                2'd0:    digito = bcd_reg[3:0];
                2'd1:    digito = bcd_reg[7:4];
                default: digito = bcd_reg[11:8];
            endcase
        end
    end

    assign una_activa = 3'b001 << indice;
    assign anodos     = ANODO_ACTIVO_BAJO ? ~una_activa : una_activa;

endmodule
